// File: rtl/riscy_pkg.sv
// Shared register-file definitions: default widths, the hard-wired zero
// register index and the address/data/counter typedefs used by reg_file,
// its write decoder and the bench.
package riscy_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ZERO_REG = 0;
    localparam int CNT_W    = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [CNT_W-1:0]  wr_count_t;

endpackage

// File: rtl/reg_wr_decode.sv
// Write-port decoder: turns (wr_en, wr_addr) into a one-hot write-select
// vector with one bit per register. Bit ZERO_REG is always 0, so the zero
// register can never be loaded and a write to it never counts as committed.
module reg_wr_decode #(
    parameter int ADDR_W = riscy_pkg::ADDR_W
) (
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    output logic [(1<<ADDR_W)-1:0]   wr_sel
);
    import riscy_pkg::*;

    // One-hot decode of the destination register, zero register masked off.
    always_comb begin
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
        wr_sel[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with a hard-wired zero register and a
// 16-bit committed-write counter for debug. Reads are combinational.
// Optional build macro REG_FILE_BYPASS_EN: a read of the register being
// written in the same cycle returns wr_data instead of the old contents.
// Storage is plain flops so that the asynchronous reset clears every entry.
module reg_file #(
    parameter int DATA_W = riscy_pkg::DATA_W,
    parameter int ADDR_W = riscy_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       wr_count
);
    import riscy_pkg::*;

    localparam int              NREGS     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0]  wr_sel;
    logic              wr_commit;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    reg_wr_decode #(
        .ADDR_W (ADDR_W)
    ) u_wr_decode (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_sel  (wr_sel)
    );

    // A write commits only when it selects a real (non-zero) register.
    assign wr_commit = |wr_sel;

    // Next-state for the array and the wrapping commit counter.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel[i]) begin
                regs_d[i] = wr_data;
            end
        end
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // Register array and counter, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Combinational read ports; the zero register reads 0 regardless of storage.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (rs_addr == ZERO_ADDR) begin
            rs_data = '0;
        end
        if (rt_addr == ZERO_ADDR) begin
            rt_data = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        // Forwarding is gated by rst_n so reads stay 0 throughout reset.
        if (rst_n && wr_commit && (rs_addr == wr_addr)) begin
            rs_data = wr_data;
        end
        if (rst_n && wr_commit && (rt_addr == wr_addr)) begin
            rt_data = wr_data;
        end
`endif
    end

    assign wr_count = wr_count_q;

    // An unknown destination during a write is left visible and flagged here.
    wr_addr_known_a : assert property (
        @(posedge clk) disable iff (!rst_n) wr_en |-> !$isunknown(wr_addr)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Expected values come from a reference
// array and counter kept by the bench, pushed to a scoreboard queue when the
// stimulus is driven and popped when the read ports are sampled.
// Build with +define+REG_FILE_BYPASS_EN to check the forwarding variant.
module tb_reg_file;
    import riscy_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_addr_t rs_addr, rt_addr, wr_addr;
    reg_data_t rs_data, rt_data, wr_data;
    logic      wr_en;
    wr_count_t wr_count;

    always #5 clk = ~clk;

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_count (wr_count)
    );

    typedef struct {
        string     name;
        reg_data_t val;
    } exp_t;

    exp_t      sb[$];
    reg_data_t mdl [NUM_REGS];
    wr_count_t cnt_mdl;
    int        vectors     = 0;
    int        miscompares = 0;

    task automatic push_exp(input string n, input reg_data_t v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Reference model of one committed edge.
    task automatic model_write(input reg_addr_t a, input reg_data_t d);
        if (a != reg_addr_t'(ZERO_REG)) begin
            mdl[a]  = d;
            cnt_mdl = cnt_mdl + 16'd1;
        end
    endtask

    // One write cycle: drive at negedge, commit at posedge, release after.
    task automatic drive_write(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_write(a, d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        cnt_mdl = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        // all registers and the counter after power-on reset
        for (int a = 0; a < NUM_REGS; a++) push_exp($sformatf("por_r%0d", a), mdl[a]);
        for (int a = 0; a < NUM_REGS; a++) begin
            rs_addr = reg_addr_t'(a);
            #1;
            e = sb.pop_front();
            vectors++;
            if (rs_data !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
            end
        end
        push_exp("por_count", 32'(cnt_mdl));
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end

        drive_write(5'd5, 32'h0000_1234);
        rs_addr = 5'd5;
        push_exp("r5_loaded", mdl[5]);
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end

        // assert reset mid-cycle, no clock edge in between
        #2;
        rst_n = 1'b0;
        model_reset();
        push_exp("rst_r5_async", mdl[5]);
        push_exp("rst_count_async", 32'(cnt_mdl));
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end

        // writes attempted while in reset are ignored and reads stay 0
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h0000_AAAA;
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        push_exp("rst_rs_during_write", 32'h0);
        push_exp("rst_rt_during_write", 32'h0);
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if (rt_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rt_data, e.val);
        end
        @(posedge clk);
        #1;
        push_exp("rst_r5_after_edge", 32'h0);
        push_exp("rst_count_after_edge", 32'h0);
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end

        // release reset mid-cycle with the write still asserted
        #2;
        rst_n = 1'b1;
`ifdef REG_FILE_BYPASS_EN
        push_exp("rel_r5_before_edge", 32'h0000_AAAA);
`else
        push_exp("rel_r5_before_edge", 32'h0);
`endif
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        model_write(5'd5, 32'h0000_AAAA);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        push_exp("rel_r5_first_edge", mdl[5]);
        push_exp("rel_count_first_edge", 32'(cnt_mdl));
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
    endtask

    task automatic test_basic_write();
        exp_t e;
        drive_write(5'd17, 32'hDEAD_BEEF);
        rs_addr = 5'd17;
        push_exp("basic_r17", mdl[17]);
        push_exp("basic_count", 32'(cnt_mdl));
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        drive_write(5'd0, 32'hFFFF_FFFF);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        push_exp("zero_rs", 32'h0);
        push_exp("zero_rt", 32'h0);
        push_exp("zero_count", 32'(cnt_mdl));
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if (rt_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rt_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
    endtask

    task automatic test_write_gating();
        exp_t e;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 5'd4;
        wr_data = 32'h0000_0055;
        @(posedge clk);
        #1;
        rs_addr = 5'd4;
        push_exp("gated_r4", mdl[4]);
        push_exp("gated_count", 32'(cnt_mdl));
        #1;
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        drive_write(5'd9, 32'h0000_0011);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h0000_0022;
        rt_addr = 5'd9;
        rs_addr = 5'd17;
`ifdef REG_FILE_BYPASS_EN
        push_exp("same_rt_before_edge", 32'h0000_0022);
`else
        push_exp("same_rt_before_edge", mdl[9]);
`endif
        push_exp("same_rs_other_reg", mdl[17]);
        #1;
        e = sb.pop_front();
        vectors++;
        if (rt_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rt_data, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
        model_write(5'd9, 32'h0000_0022);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        push_exp("same_rt_after_edge", mdl[9]);
        e = sb.pop_front();
        vectors++;
        if (rt_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rt_data, e.val);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = reg_addr_t'(20 + i);
            wr_data = $urandom;
            model_write(wr_addr, wr_data);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        for (int a = 18; a < 30; a++) begin
            rs_addr = reg_addr_t'(a);
            rt_addr = reg_addr_t'(a);
            push_exp($sformatf("b2b_rs_r%0d", a), mdl[a]);
            push_exp($sformatf("b2b_rt_r%0d", a), mdl[a]);
            #1;
            e = sb.pop_front();
            vectors++;
            if (rs_data !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
            end
            e = sb.pop_front();
            vectors++;
            if (rt_data !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, rt_data, e.val);
            end
        end
        push_exp("b2b_count", 32'(cnt_mdl));
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
    endtask

    task automatic test_counter_wrap();
        exp_t e;
        int   n;
        n = 32'hFFFF - int'(cnt_mdl);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = reg_addr_t'((i % (NUM_REGS - 1)) + 1);
            wr_data = reg_data_t'(i);
            model_write(wr_addr, wr_data);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        push_exp("wrap_preload", 32'(cnt_mdl));
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
        drive_write(5'd3, 32'h00C0_FFEE);
        rs_addr = 5'd3;
        push_exp("wrap_count", 32'(cnt_mdl));
        push_exp("wrap_r3", mdl[3]);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({16'd0, wr_count} !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, wr_count, e.val);
        end
        e = sb.pop_front();
        vectors++;
        if (rs_data !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, rs_data, e.val);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rs_addr = '0;
        rt_addr = '0;
        model_reset();
        #17;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_write_gating();
        test_same_cycle();
        test_back_to_back();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
